// File: rtl/img_stream_pkg.sv
// Shared types and constants for the image stream monitor.
package img_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TAIL   = 2'd2
  } mon_state_t;

  // Channel index within a pixel; the bit offset is index*DATA_W (R sits in the MSBs)
  localparam int R_OFS = 32'sd2;
  localparam int G_OFS = 32'sd1;
  localparam int B_OFS = 32'sd0;

  function automatic int beats_per_line(input int img_w, input int pix_per_clk);
    return img_w / pix_per_clk;
  endfunction

endpackage

// File: rtl/img_beat_sum.sv
// Combinational sum of all channel bytes carried by one beat.
module img_beat_sum #(
  parameter int N_BYTES = 6,
  parameter int DATA_W  = 8,
  parameter int SUM_W   = DATA_W + $clog2(N_BYTES)
) (
  input  logic [N_BYTES*DATA_W-1:0] data,
  output logic [SUM_W-1:0]          sum
);

  // zero-extend every byte to the result width before adding
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      sum = sum + SUM_W'(data[i*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/img_stream_monitor.sv
// Pixel-stream framing monitor: checks VSYNC/HSYNC framing, counts beats/lines/frames, checksums frames.
// Define MON_MINMAX_EN to add per-channel min/max outputs latched on each clean frame.
module img_stream_monitor
  import img_stream_pkg::*;
#(
  parameter int PIX_PER_CLK = 2,
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 768,
  parameter int IMG_H       = 512,
  parameter int CHK_W       = 32
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic                            VSYNC,
  input  logic                            HSYNC,
  input  logic [PIX_PER_CLK*3*DATA_W-1:0] DATA_IN,
  input  logic                            clr_err,
  output logic                            frame_done,
  output logic [15:0]                     frame_cnt,
  output logic [CHK_W-1:0]                checksum,
`ifdef MON_MINMAX_EN
  output logic [DATA_W-1:0]               min_r,
  output logic [DATA_W-1:0]               max_r,
  output logic [DATA_W-1:0]               min_g,
  output logic [DATA_W-1:0]               max_g,
  output logic [DATA_W-1:0]               min_b,
  output logic [DATA_W-1:0]               max_b,
`endif
  output logic                            err_line_short,
  output logic                            err_line_long,
  output logic                            err_frame,
  output logic                            busy
);

  localparam int BEATS   = beats_per_line(IMG_W, PIX_PER_CLK);
  localparam int N_BYTES = 3 * PIX_PER_CLK;
  localparam int SUM_W   = DATA_W + $clog2(N_BYTES);
  localparam int BEAT_W  = $clog2(BEATS + 1);
  localparam int LINE_W  = $clog2(IMG_H + 1);
  localparam logic [BEAT_W-1:0] BEATS_V     = BEAT_W'(BEATS);
  localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE    = LINE_W'(1);
  localparam logic [LINE_W-1:0] LAST_LINE_V = LINE_W'(IMG_H - 1);

  mon_state_t        state_r, state_nxt_s;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic [LINE_W-1:0] line_cnt_r;
  logic [CHK_W-1:0]  acc_r;
  logic              hsync_d_r;
  logic              frm_err_r;
  logic              frame_done_r;
  logic [15:0]       frame_cnt_r;
  logic [CHK_W-1:0]  checksum_r;
  logic              err_short_r, err_long_r, err_frame_r, busy_r;

  logic              start_s, beat_s, fall_s, frame_end_s, clean_s;
  logic              evt_short_s, evt_long_s, evt_frame_s;
  logic [SUM_W-1:0]  beat_sum_s;
  logic [CHK_W-1:0]  beat_sum_ext_s;

  img_beat_sum #(
    .N_BYTES (N_BYTES),
    .DATA_W  (DATA_W),
    .SUM_W   (SUM_W)
  ) u_beat_sum (
    .data (DATA_IN),
    .sum  (beat_sum_s)
  );

  assign beat_sum_ext_s = CHK_W'(beat_sum_s);
  assign clean_s        = ~frm_err_r & ~evt_short_s;

  // state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state and per-cycle framing events; VSYNC always wins over line handling
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    beat_s      = 1'b0;
    fall_s      = 1'b0;
    frame_end_s = 1'b0;
    evt_short_s = 1'b0;
    evt_long_s  = 1'b0;
    evt_frame_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (VSYNC) begin
          start_s     = 1'b1;
          state_nxt_s = ACTIVE;
        end else if (HSYNC) begin
          evt_frame_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (VSYNC) begin
          evt_frame_s = 1'b1;
          start_s     = 1'b1;
        end else if (HSYNC) begin
          if (beat_cnt_r == BEATS_V) begin
            evt_long_s = 1'b1;
          end else begin
            beat_s = 1'b1;
          end
        end else if (hsync_d_r) begin
          fall_s      = 1'b1;
          evt_short_s = (beat_cnt_r != BEATS_V);
          if (line_cnt_r == LAST_LINE_V) begin
            frame_end_s = 1'b1;
            state_nxt_s = TAIL;
          end else begin
            state_nxt_s = ACTIVE;
          end
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      TAIL: begin
        if (VSYNC) begin
          start_s     = 1'b1;
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // counters, accumulator, frame results and sticky error flags
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt_r   <= '0;
      line_cnt_r   <= '0;
      acc_r        <= '0;
      hsync_d_r    <= 1'b0;
      frm_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
      checksum_r   <= '0;
      err_short_r  <= 1'b0;
      err_long_r   <= 1'b0;
      err_frame_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      hsync_d_r <= HSYNC;
      busy_r    <= (state_nxt_s != IDLE);

      // a beat arriving with VSYNC is beat 1 of the new frame
      if (start_s) begin
        beat_cnt_r <= HSYNC ? BEAT_ONE : '0;
        line_cnt_r <= '0;
        acc_r      <= HSYNC ? beat_sum_ext_s : '0;
        frm_err_r  <= 1'b0;
      end else begin
        if (beat_s) begin
          beat_cnt_r <= beat_cnt_r + BEAT_ONE;
          acc_r      <= acc_r + beat_sum_ext_s;
        end else if (fall_s) begin
          beat_cnt_r <= '0;
          line_cnt_r <= line_cnt_r + LINE_ONE;
        end else begin
          beat_cnt_r <= beat_cnt_r;
        end
        frm_err_r <= frm_err_r | evt_short_s | evt_long_s;
      end

      // results are registered on the edge entering TAIL so the pulse is visible during TAIL
      if (frame_end_s && clean_s) begin
        frame_done_r <= 1'b1;
        checksum_r   <= acc_r;
        frame_cnt_r  <= frame_cnt_r + 16'd1;
      end else begin
        frame_done_r <= 1'b0;
      end

      // a new error event has priority over the clear
      if (evt_short_s)  err_short_r <= 1'b1;
      else if (clr_err) err_short_r <= 1'b0;
      else              err_short_r <= err_short_r;

      if (evt_long_s)   err_long_r <= 1'b1;
      else if (clr_err) err_long_r <= 1'b0;
      else              err_long_r <= err_long_r;

      if (evt_frame_s)  err_frame_r <= 1'b1;
      else if (clr_err) err_frame_r <= 1'b0;
      else              err_frame_r <= err_frame_r;
    end
  end

  assign frame_done     = frame_done_r;
  assign frame_cnt      = frame_cnt_r;
  assign checksum       = checksum_r;
  assign err_line_short = err_short_r;
  assign err_line_long  = err_long_r;
  assign err_frame      = err_frame_r;
  assign busy           = busy_r;

`ifdef MON_MINMAX_EN
  logic [2:0][DATA_W-1:0] bmin_s, bmax_s, mmin_s, mmax_s;
  logic [2:0][DATA_W-1:0] run_min_r, run_max_r, out_min_r, out_max_r;
  logic [DATA_W-1:0]      chan_s;

  // extremes within this beat, then merged with the running frame extremes
  always_comb begin
    bmin_s = '1;
    bmax_s = '0;
    chan_s = '0;
    for (int p = 0; p < PIX_PER_CLK; p++) begin
      for (int c = 0; c < 3; c++) begin
        chan_s    = DATA_IN[(p*3 + c)*DATA_W +: DATA_W];
        bmin_s[c] = (chan_s < bmin_s[c]) ? chan_s : bmin_s[c];
        bmax_s[c] = (chan_s > bmax_s[c]) ? chan_s : bmax_s[c];
      end
    end
    for (int c = 0; c < 3; c++) begin
      mmin_s[c] = (bmin_s[c] < run_min_r[c]) ? bmin_s[c] : run_min_r[c];
      mmax_s[c] = (bmax_s[c] > run_max_r[c]) ? bmax_s[c] : run_max_r[c];
    end
  end

  // running extremes track accumulated beats only and are published with the checksum
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      run_min_r <= '1;
      run_max_r <= '0;
      out_min_r <= '0;
      out_max_r <= '0;
    end else begin
      if (start_s) begin
        run_min_r <= HSYNC ? bmin_s : '1;
        run_max_r <= HSYNC ? bmax_s : '0;
      end else if (beat_s) begin
        run_min_r <= mmin_s;
        run_max_r <= mmax_s;
      end else begin
        run_min_r <= run_min_r;
        run_max_r <= run_max_r;
      end
      if (frame_end_s && clean_s) begin
        out_min_r <= run_min_r;
        out_max_r <= run_max_r;
      end else begin
        out_min_r <= out_min_r;
        out_max_r <= out_max_r;
      end
    end
  end

  assign min_r = out_min_r[R_OFS];
  assign max_r = out_max_r[R_OFS];
  assign min_g = out_min_r[G_OFS];
  assign max_g = out_max_r[G_OFS];
  assign min_b = out_min_r[B_OFS];
  assign max_b = out_max_r[B_OFS];
`endif

endmodule

// File: tb/tb_img_stream_monitor.sv
// Directed self-checking bench for img_stream_monitor (PIX_PER_CLK=2, IMG_W=8, IMG_H=4).
module tb_img_stream_monitor;

  localparam int PPC = 2;
  localparam int DW  = 8;
  localparam int IW  = 8;
  localparam int IH  = 4;
  localparam int CW  = 32;
  localparam int WW  = PPC * 3 * DW;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          VSYNC   = 1'b0;
  logic          HSYNC   = 1'b0;
  logic          clr_err = 1'b0;
  logic [WW-1:0] DATA_IN = '0;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic [CW-1:0] checksum;
  logic          err_line_short, err_line_long, err_frame, busy;
`ifdef MON_MINMAX_EN
  logic [DW-1:0] min_r, max_r, min_g, max_g, min_b, max_b;
`endif

  int tests_run     = 0;
  int tests_failed  = 0;
  int cyc           = 0;
  int done_cnt      = 0;
  int done_cyc      = 0;
  int last_beat_cyc = 0;
  int d0;

  img_stream_monitor #(
    .PIX_PER_CLK (PPC),
    .DATA_W      (DW),
    .IMG_W       (IW),
    .IMG_H       (IH),
    .CHK_W       (CW)
  ) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .VSYNC          (VSYNC),
    .HSYNC          (HSYNC),
    .DATA_IN        (DATA_IN),
    .clr_err        (clr_err),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .checksum       (checksum),
`ifdef MON_MINMAX_EN
    .min_r          (min_r),
    .max_r          (max_r),
    .min_g          (min_g),
    .max_g          (max_g),
    .min_b          (min_b),
    .max_b          (max_b),
`endif
    .err_line_short (err_line_short),
    .err_line_long  (err_line_long),
    .err_frame      (err_frame),
    .busy           (busy)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  // frame_done pulses sampled mid-cycle
  always @(negedge HCLK) begin
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [WW-1:0] d, input logic c);
    VSYNC = v; HSYNC = h; DATA_IN = d; clr_err = c;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_line(input int nb, input logic [7:0] b, input logic vfirst);
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1) last_beat_cyc = cyc;
      step(vfirst && (i == 0), 1'b1, {(PPC*3){b}}, 1'b0);
    end
  endtask

  // vmode: 0 = own VSYNC cycle, 1 = VSYNC on first beat, 2 = VSYNC already sent
  task automatic send_frame(input logic [7:0] b, input int n0, input int n1,
                            input int n2, input int n3, input int vmode);
    if (vmode == 0) step(1'b1, 1'b0, '0, 1'b0);
    send_line(n0, b, vmode == 1); idle(2);
    send_line(n1, b, 1'b0);       idle(2);
    send_line(n2, b, 1'b0);       idle(2);
    send_line(n3, b, 1'b0);       idle(2);
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_val("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check_val("rst_checksum", checksum, 32'd0);
    check_val("rst_errs", {29'd0, err_line_short, err_line_long, err_frame}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    HRESETn = 1'b1;
    idle(2);

    // clean frame of 0x01
    d0 = done_cnt;
    step(1'b1, 1'b0, '0, 1'b0);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    send_frame(8'h01, 4, 4, 4, 4, 2);
    check_val("t1_done_pulses", done_cnt - d0, 32'd1);
    check_val("t1_latency", done_cyc - last_beat_cyc, 32'd2);
    check_val("t1_checksum", checksum, 32'd96);
    check_val("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check_val("t1_errs", {29'd0, err_line_short, err_line_long, err_frame}, 32'd0);
    check_val("t1_idle", {31'd0, busy}, 32'd0);

    // short second line
    d0 = done_cnt;
    send_frame(8'h01, 4, 3, 4, 4, 0);
    check_val("t2_short", {31'd0, err_line_short}, 32'd1);
    check_val("t2_no_done", done_cnt - d0, 32'd0);
    check_val("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check_val("t2_checksum", checksum, 32'd96);
    check_val("t2_idle", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("t2_clr", {31'd0, err_line_short}, 32'd0);

    // long first line of 0xFF
    d0 = done_cnt;
    send_frame(8'hFF, 5, 4, 4, 4, 0);
    check_val("t3_long", {31'd0, err_line_long}, 32'd1);
    check_val("t3_not_short", {31'd0, err_line_short}, 32'd0);
    check_val("t3_no_done", done_cnt - d0, 32'd0);
    check_val("t3_checksum", checksum, 32'd96);
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("t3_clr", {31'd0, err_line_long}, 32'd0);

    // HSYNC in IDLE; clear colliding with a new event keeps the flag
    step(1'b0, 1'b1, '0, 1'b0);
    check_val("idle_hsync_err", {31'd0, err_frame}, 32'd1);
    step(1'b0, 1'b1, '0, 1'b1);
    check_val("clr_vs_event", {31'd0, err_frame}, 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("clr_frame", {31'd0, err_frame}, 32'd0);

    // VSYNC after two lines, then a clean frame of 0x02
    d0 = done_cnt;
    step(1'b1, 1'b0, '0, 1'b0);
    send_line(4, 8'h01, 1'b0); idle(2);
    send_line(4, 8'h01, 1'b0); idle(2);
    send_frame(8'h02, 4, 4, 4, 4, 0);
    check_val("t4_err_frame", {31'd0, err_frame}, 32'd1);
    check_val("t4_done_pulses", done_cnt - d0, 32'd1);
    check_val("t4_checksum", checksum, 32'd192);
    check_val("t4_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    step(1'b0, 1'b0, '0, 1'b1);

    // VSYNC coincident with the first beat
    d0 = done_cnt;
    send_frame(8'h01, 4, 4, 4, 4, 1);
    check_val("vh_done_pulses", done_cnt - d0, 32'd1);
    check_val("vh_checksum", checksum, 32'd96);
    check_val("vh_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    check_val("vh_errs", {29'd0, err_line_short, err_line_long, err_frame}, 32'd0);

    // reset during line 3, then a clean frame
    step(1'b1, 1'b0, '0, 1'b0);
    send_line(4, 8'h05, 1'b0); idle(2);
    send_line(4, 8'h05, 1'b0); idle(2);
    step(1'b0, 1'b1, {(PPC*3){8'h05}}, 1'b0);
    step(1'b0, 1'b1, {(PPC*3){8'h05}}, 1'b0);
    HRESETn = 1'b0;
    #2;
    check_val("t5_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check_val("t5_rst_checksum", checksum, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_val("t5_rst_done", {31'd0, frame_done}, 32'd0);
    VSYNC = 1'b0; HSYNC = 1'b0; DATA_IN = '0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    d0 = done_cnt;
    send_frame(8'h01, 4, 4, 4, 4, 0);
    check_val("t5_done_pulses", done_cnt - d0, 32'd1);
    check_val("t5_checksum", checksum, 32'd96);
    check_val("t5_frame_cnt", {16'd0, frame_cnt}, 32'd1);

`ifdef MON_MINMAX_EN
    // R ramps 0x10..0x2F over 32 pixels, G=B=0x80
    step(1'b1, 1'b0, '0, 1'b0);
    for (int ln = 0; ln < 4; ln++) begin
      for (int bt = 0; bt < 4; bt++) begin
        logic [7:0] r0, r1;
        r0 = 8'h10 + 8'(2 * (ln * 4 + bt));
        r1 = r0 + 8'h01;
        step(1'b0, 1'b1, {r1, 8'h80, 8'h80, r0, 8'h80, 8'h80}, 1'b0);
      end
      idle(2);
    end
    check_val("t6_min_r", {24'd0, min_r}, 32'h10);
    check_val("t6_max_r", {24'd0, max_r}, 32'h2F);
    check_val("t6_min_g", {24'd0, min_g}, 32'h80);
    check_val("t6_max_g", {24'd0, max_g}, 32'h80);
    check_val("t6_min_b", {24'd0, min_b}, 32'h80);
    check_val("t6_max_b", {24'd0, max_b}, 32'h80);
    check_val("t6_checksum", checksum, 32'd9200);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/img_stream_monitor.md
Name: img_stream_monitor

Overview:
Parametrised pixel-stream monitor placed between the image source and the image sink. It checks the VSYNC/HSYNC framing of an N-pixels-per-clock RGB stream, counts beats, lines and frames, and accumulates a per-frame checksum. It reports completed-frame results and sticky protocol errors, and is synthesizable so the same block runs in simulation and on the DE0 board.

Parameters:
PIX_PER_CLK, 2, pixels carried per beat (1, 2 or 4)
DATA_W, 8, bits per colour channel
IMG_W, 768, pixels per line; must be a multiple of PIX_PER_CLK
IMG_H, 512, lines per frame
CHK_W, 32, checksum width

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
VSYNC  in  1  one-cycle frame-start pulse
HSYNC  in  1  data-valid; high for every active beat of a line
DATA_IN  in  PIX_PER_CLK*3*DATA_W  pixel word; pixel k occupies bits [k*3*DATA_W +: 3*DATA_W]; within a pixel R is in the MSBs, then G, then B
clr_err  in  1  synchronous clear of the sticky error flags
frame_done  out  1  one-cycle pulse when a frame completes cleanly
frame_cnt  out  16  count of clean frames; wraps at 2^16
checksum  out  CHK_W  checksum of the last clean frame
err_line_short  out  1  sticky: HSYNC fell before BEATS beats
err_line_long  out  1  sticky: HSYNC stayed high past BEATS beats
err_frame  out  1  sticky: VSYNC arrived mid-frame, or HSYNC was seen in IDLE
busy  out  1  high while in ACTIVE or TAIL

Behaviour:
- Reset: all outputs are 0. Internal counters and the accumulator are 0. State is IDLE.
- Constants: BEATS = IMG_W/PIX_PER_CLK.
- Internal counters: beat_cnt is clog2(BEATS+1) bits; line_cnt is clog2(IMG_H+1) bits.
- FSM states: IDLE, ACTIVE, TAIL.
- IDLE:
  - VSYNC=1 moves to ACTIVE and zeroes beat_cnt, line_cnt and the accumulator.
  - HSYNC=1 with no VSYNC sets err_frame; the data is ignored.
- ACTIVE, beat with HSYNC=1:
  - The accumulator adds the zero-extended sum of all 3*PIX_PER_CLK channel bytes in the beat, modulo 2^CHK_W.
  - beat_cnt increments.
  - If beat_cnt already equals BEATS, set err_line_long and do not accumulate the beat.
- ACTIVE, HSYNC falling (previous HSYNC=1, current HSYNC=0):
  - beat_cnt==BEATS: line_cnt increments and beat_cnt clears.
  - beat_cnt<BEATS: set err_line_short, clear beat_cnt, and count the line anyway so a frame still terminates.
  - After a long line, clear beat_cnt and count the line.
- Line completion: when the counted line makes line_cnt reach IMG_H, go to TAIL.
- TAIL (one cycle):
  - If no error was raised since the frame's VSYNC: frame_done=1 in this cycle, checksum takes the accumulator value, frame_cnt increments.
  - Otherwise no pulse and checksum holds its previous value.
  - Next state is IDLE.
  - Latency: frame_done is 2 cycles after the last HSYNC-high beat.
- VSYNC while in ACTIVE: set err_frame, abandon the frame without a frame_done pulse, and restart as if from IDLE in the same cycle.
- VSYNC and HSYNC high together: the VSYNC transition is taken first, and the beat counts as beat 1 of the new frame.
- Sticky errors:
  - Held until clr_err=1 or reset.
  - When clr_err and a new error event occur in the same cycle, the new error wins and the flag stays set.
- A per-frame error flag, cleared by VSYNC, gates frame_done. It is separate from the sticky flags.
- Reset mid-frame returns to IDLE immediately; all outputs go to 0.

Optional Feature:
Macro MON_MINMAX_EN.
- Defined: adds outputs min_r, max_r, min_g, max_g, min_b, max_b, each DATA_W bits.
  - Running min and max per channel are taken over every pixel of every accumulated beat.
  - Running values initialise to all-ones (min) and 0 (max) on VSYNC.
  - They are latched to the outputs together with checksum on a clean frame.
  - Reset value of the outputs is 0.
- Undefined: these ports and their logic are absent; everything else is unchanged.

Decomposition:
- Package img_stream_pkg holds:
  - the FSM state enum (IDLE, ACTIVE, TAIL)
  - the channel offset constants R_OFS, G_OFS, B_OFS
  - the helper function beats_per_line(IMG_W, PIX_PER_CLK)
- One natural sub-module, img_beat_sum: a purely combinational adder tree summing 3*PIX_PER_CLK bytes into a DATA_W+clog2(3*PIX_PER_CLK)-bit result. The top instantiates it once.

Test Plan:
All scenarios use PIX_PER_CLK=2, IMG_W=8, IMG_H=4 (BEATS=4).
1. Clean frame: VSYNC pulse, then 4 lines of 4 HSYNC beats with every byte 0x01, 2-cycle gaps between lines -> frame_done pulses once 2 cycles after the last beat; checksum=96 (0x60); frame_cnt=1; all errors 0.
2. Short line: line 2 has 3 beats -> err_line_short=1, no frame_done, frame_cnt stays 1, checksum stays 96; clr_err then clears the flag.
3. Long line: line 1 has 5 beats of 0xFF -> err_line_long=1; the 5th beat is not accumulated; no frame_done.
4. Mid-frame VSYNC after 2 lines, followed by a full clean frame of byte 0x02 -> err_frame=1 from the first frame; the second frame gives frame_done, checksum=192, frame_cnt increments by 1.
5. Reset asserted during line 3, then a clean frame -> all outputs 0 during reset; the following frame completes normally with checksum=96.
6. MON_MINMAX_EN defined: one frame where R bytes ramp 0x10..0x2F and G=B=0x80 -> min_r=0x10, max_r=0x2F, min_g=max_g=min_b=max_b=0x80.
